coherence_bus_arbiter: RTL and testbench

- Upstream bus controller that feeds the MESI coherency unit.
- Arbitrates L1 miss, read-exclusive and writeback requests from CPUS data caches, one transaction at a time.
- Sequences each granted transaction through snoop broadcast, cache-to-cache or L2 transfer, and completion.
- Publishes the current bus state (GRANT_R/GRANT_RX/...) that the coherency unit keys its transitions on.

---
 rtl/coherence_bus_arbiter_pkg.sv | 22 ++
 rtl/coherence_bus_arbiter_rr.sv | 33 +++
 rtl/coherence_bus_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared encodings between the coherence bus arbiter and the MESI coherency unit.
// The bus state values are observed directly by the coherency unit.
package coherence_bus_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT_R   = 3'd1,
        GRANT_RX  = 3'd2,
        SNOOP     = 3'd3,
        L2_READ   = 3'd4,
        C2C       = 3'd5,
        WRITEBACK = 3'd6,
        DONE      = 3'd7
    } bus_state_t;

    typedef enum logic [1:0] {
        REQ_R  = 2'd0,
        REQ_RX = 2'd1,
        REQ_WB = 2'd2
    } req_type_t;

endpackage

// File: rtl/coherence_bus_arbiter_rr.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
// Produces a one-hot grant vector and the winner's index.
module rr_arbiter
    import coherence_bus_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id
);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Coherence bus arbiter: grants one L1 miss/RX/writeback at a time and walks it through
// snoop, C2C or L2 transfer and completion. Optional snoop watchdog: BUS_SNOOP_TIMEOUT_EN.
module coherence_bus_arbiter
    import coherence_bus_pkg::*;
#(
    parameter int CPUS           = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [CPUS-1:0]            bus_req,
    input  logic [CPUS-1:0]            bus_rx,
    input  logic [CPUS-1:0]            bus_wb,
    input  logic [CPUS*ADDR_WIDTH-1:0] bus_addr,
    input  logic [CPUS*DATA_WIDTH-1:0] bus_wdata,
    output logic [CPUS-1:0]            bus_done,
    output logic [DATA_WIDTH-1:0]      bus_rdata,
    output logic                       bus_exclusive,
    output logic [2:0]                 bus_state,
    output logic                       snoop_valid,
    output logic                       snoop_inv,
    output logic [ADDR_WIDTH-1:0]      snoop_addr,
    output logic [CPUS-1:0]            snoop_mask,
    input  logic [CPUS-1:0]            snoop_done,
    input  logic [CPUS-1:0]            snoop_hit,
    input  logic [CPUS-1:0]            snoop_dirty,
    input  logic [CPUS*DATA_WIDTH-1:0] snoop_data,
    output logic                       l2_ren,
    output logic                       l2_wen,
    output logic [ADDR_WIDTH-1:0]      l2_addr,
    output logic [DATA_WIDTH-1:0]      l2_wdata,
    input  logic [DATA_WIDTH-1:0]      l2_rdata,
`ifdef BUS_SNOOP_TIMEOUT_EN
    output logic                       timeout_err,
`endif
    input  logic                       l2_ready
);

    localparam int ID_W = (CPUS > 1) ? $clog2(CPUS) : 1;

    if (CPUS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("coherence_bus_arbiter: CPUS must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    bus_state_t            state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, id_q, win_id;
    req_type_t             type_q, win_type;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, fill_q;
    logic                  hit_any_q;

    logic [CPUS-1:0]       wb_grant, rd_grant, mask, dirty_vec;
    logic [ID_W-1:0]       wb_id, rd_id, sup_id;
    logic                  snoop_all_done, any_dirty, grant_now, snoop_exit, to_expire;

    function automatic logic [ID_W-1:0] lowest_set(input logic [CPUS-1:0] v);
        lowest_set = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = ID_W'(i);
        end
    endfunction

    // Writebacks and read requests are arbitrated as separate classes sharing rr_ptr.
    rr_arbiter #(.N(CPUS), .IW(ID_W)) u_rr_wb (
        .req      (bus_wb),
        .ptr      (rr_ptr_q),
        .grant    (wb_grant),
        .grant_id (wb_id)
    );

    rr_arbiter #(.N(CPUS), .IW(ID_W)) u_rr_req (
        .req      (bus_req),
        .ptr      (rr_ptr_q),
        .grant    (rd_grant),
        .grant_id (rd_id)
    );

    always_comb begin
        mask = '0;
        for (int i = 0; i < CPUS; i++) begin
            mask[i] = (ID_W'(i) != id_q);
        end
    end

    assign dirty_vec      = snoop_dirty & mask;
    assign any_dirty      = |dirty_vec;
    assign sup_id         = lowest_set(dirty_vec);
    assign snoop_all_done = ((snoop_done & mask) == mask);

`ifdef BUS_SNOOP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;

    assign to_expire = (state_q == SNOOP) && !snoop_all_done &&
                       (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            to_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_q == SNOOP) to_cnt_q <= to_cnt_q + CNT_W'(1);
            else                  to_cnt_q <= '0;
            if (to_expire) timeout_err <= 1'b1;
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        win_id   = wb_id;
        win_type = REQ_WB;
        case (state_q)
            IDLE: begin
                if (|wb_grant) begin
                    state_d = WRITEBACK;
                end else if (|rd_grant) begin
                    win_id   = rd_id;
                    win_type = bus_rx[rd_id] ? REQ_RX : REQ_R;
                    state_d  = bus_rx[rd_id] ? GRANT_RX : GRANT_R;
                end
            end
            GRANT_R, GRANT_RX: state_d = SNOOP;
            SNOOP: begin
                if (snoop_all_done) state_d = any_dirty ? C2C : L2_READ;
                else if (to_expire) state_d = L2_READ;
            end
            L2_READ, C2C, WRITEBACK: begin
                if (l2_ready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant_now  = (state_q == IDLE) && (state_d != IDLE);
    assign snoop_exit = (state_q == SNOOP) && snoop_all_done;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            type_q    <= REQ_R;
            addr_q    <= '0;
            wdata_q   <= '0;
            fill_q    <= '0;
            hit_any_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_now) begin
                id_q      <= win_id;
                type_q    <= win_type;
                addr_q    <= bus_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q   <= bus_wdata[win_id*DATA_WIDTH +: DATA_WIDTH];
                fill_q    <= '0;
                hit_any_q <= 1'b0;
            end
            // A dirty responder counts as a hit, so a C2C-filled read is never installed E.
            if (snoop_exit) begin
                hit_any_q <= |((snoop_hit | snoop_dirty) & mask);
                if (any_dirty) fill_q <= snoop_data[sup_id*DATA_WIDTH +: DATA_WIDTH];
            end else if (to_expire) begin
                hit_any_q <= |(snoop_hit & snoop_done & mask);
            end
            if (state_q == L2_READ && l2_ready) fill_q <= l2_rdata;
            if (state_q == DONE) begin
                rr_ptr_q <= (id_q == ID_W'(CPUS - 1)) ? '0 : id_q + ID_W'(1);
            end
        end
    end

    always_comb begin
        bus_done      = '0;
        bus_rdata     = '0;
        bus_exclusive = 1'b0;
        snoop_valid   = 1'b0;
        snoop_inv     = 1'b0;
        snoop_addr    = '0;
        snoop_mask    = '0;
        l2_ren        = 1'b0;
        l2_wen        = 1'b0;
        l2_addr       = '0;
        l2_wdata      = '0;
        case (state_q)
            GRANT_R, GRANT_RX, SNOOP: begin
                snoop_valid = 1'b1;
                snoop_inv   = (type_q == REQ_RX);
                snoop_addr  = addr_q;
                snoop_mask  = mask;
            end
            L2_READ: begin
                l2_ren  = 1'b1;
                l2_addr = addr_q;
            end
            C2C: begin
                l2_wen   = 1'b1;
                l2_addr  = addr_q;
                l2_wdata = fill_q;
            end
            WRITEBACK: begin
                l2_wen   = 1'b1;
                l2_addr  = addr_q;
                l2_wdata = wdata_q;
            end
            DONE: begin
                bus_done[id_q] = 1'b1;
                bus_rdata      = fill_q;
                bus_exclusive  = (type_q == REQ_RX) || ((type_q == REQ_R) && !hit_any_q);
            end
            default: ;
        endcase
    end

    assign bus_state = state_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter (CPUS=2): table of transactions plus
// hand-written reset-in-snoop and (with BUS_SNOOP_TIMEOUT_EN) watchdog sequences.
module tb_coherence_bus_arbiter;
    import coherence_bus_pkg::*;

    localparam int CPUS = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [1:0]      bus_req, bus_rx, bus_wb;
    logic [63:0]     bus_addr, bus_wdata;
    logic [1:0]      bus_done;
    logic [31:0]     bus_rdata;
    logic            bus_exclusive;
    logic [2:0]      bus_state;
    logic            snoop_valid, snoop_inv;
    logic [31:0]     snoop_addr;
    logic [1:0]      snoop_mask;
    logic [1:0]      snoop_done, snoop_hit, snoop_dirty;
    logic [63:0]     snoop_data;
    logic            l2_ren, l2_wen;
    logic [31:0]     l2_addr, l2_wdata, l2_rdata;
    logic            l2_ready;
`ifdef BUS_SNOOP_TIMEOUT_EN
    logic            timeout_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    coherence_bus_arbiter #(
        .CPUS(CPUS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .bus_req(bus_req), .bus_rx(bus_rx), .bus_wb(bus_wb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_done(bus_done), .bus_rdata(bus_rdata), .bus_exclusive(bus_exclusive),
        .bus_state(bus_state),
        .snoop_valid(snoop_valid), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .snoop_mask(snoop_mask), .snoop_done(snoop_done), .snoop_hit(snoop_hit),
        .snoop_dirty(snoop_dirty), .snoop_data(snoop_data),
        .l2_ren(l2_ren), .l2_wen(l2_wen), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata),
`ifdef BUS_SNOOP_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .l2_ready(l2_ready)
    );

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        excl;
        int          cyc;
        logic [1:0]  mask;
        logic        inv;
        logic        wen;
        logic [31:0] wdata;
    } done_t;

    typedef struct {
        string       name;
        logic [1:0]  req, rx, wb;
        logic [31:0] a0, a1, w0, w1;
        logic [1:0]  hit, dirty;
        logic [31:0] s0, s1, l2d;
        int          sw, lw;
        bit          drop;
        int          ndone;
        done_t       d0, d1;
    } vec_t;

    vec_t vecs[11];

    function automatic done_t mk_done(input int id, input logic [31:0] rdata, input logic excl,
                                      input int cyc, input logic [1:0] mask, input logic inv,
                                      input logic wen, input logic [31:0] wdata);
        done_t d;
        d.id = id; d.rdata = rdata; d.excl = excl; d.cyc = cyc;
        d.mask = mask; d.inv = inv; d.wen = wen; d.wdata = wdata;
        return d;
    endfunction

    function automatic vec_t mk_vec(input string nm, input logic [1:0] req, input logic [1:0] rx,
                                    input logic [1:0] wb, input logic [31:0] a0, input logic [31:0] a1,
                                    input logic [31:0] w0, input logic [31:0] w1,
                                    input logic [1:0] hit, input logic [1:0] dirty,
                                    input logic [31:0] s0, input logic [31:0] s1,
                                    input logic [31:0] l2d, input int sw, input int lw);
        vec_t v;
        v.name = nm; v.req = req; v.rx = rx; v.wb = wb;
        v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
        v.hit = hit; v.dirty = dirty; v.s0 = s0; v.s1 = s1; v.l2d = l2d;
        v.sw = sw; v.lw = lw; v.drop = 1'b0; v.ndone = 1;
        v.d0 = mk_done(0, 0, 0, 0, 0, 0, 0, 0);
        v.d1 = mk_done(0, 0, 0, 0, 0, 0, 0, 0);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, ".ctrl"}, {bus_done, bus_exclusive, bus_state, snoop_valid, snoop_inv,
                             snoop_mask, l2_ren, l2_wen}, 64'd0);
        chk({pfx, ".rdata"}, bus_rdata, 64'd0);
        chk({pfx, ".addr"}, {snoop_addr, l2_addr}, 64'd0);
        chk({pfx, ".l2wdata"}, l2_wdata, 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc, sc, lc, got, gid;
        logic [1:0]  cmask;
        logic        cinv, cwen;
        logic [31:0] cwdata, csaddr, cl2addr, ea;
        done_t       e;
        @(negedge CLK);
        bus_req = v.req; bus_rx = v.rx; bus_wb = v.wb;
        bus_addr = {v.a1, v.a0}; bus_wdata = {v.w1, v.w0};
        snoop_hit = v.hit; snoop_dirty = v.dirty; snoop_data = {v.s1, v.s0};
        l2_rdata = v.l2d; snoop_done = 2'b00; l2_ready = 1'b0;
        cyc = 1; sc = 0; lc = 0; got = 0;
        cmask = 0; cinv = 0; cwen = 0; cwdata = 0; csaddr = 0; cl2addr = 0;
        while (got < v.ndone && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            if (v.drop && cyc == 2) bus_req = 2'b00;
            if (snoop_valid) begin cmask = snoop_mask; cinv = snoop_inv; csaddr = snoop_addr; end
            if (l2_wen) begin cwen = 1'b1; cwdata = l2_wdata; end
            if (l2_ren || l2_wen) cl2addr = l2_addr;
            if (|bus_done) begin
                e   = (got == 0) ? v.d0 : v.d1;
                gid = bus_done[1] ? 1 : 0;
                ea  = (e.id == 1) ? v.a1 : v.a0;
                chk({v.name, ".done"}, bus_done, 64'(2'b01 << e.id));
                chk({v.name, ".cycle"}, cyc, e.cyc);
                chk({v.name, ".rdata"}, bus_rdata, e.rdata);
                chk({v.name, ".excl"}, bus_exclusive, e.excl);
                chk({v.name, ".smask"}, cmask, e.mask);
                chk({v.name, ".sinv"}, cinv, e.inv);
                chk({v.name, ".saddr"}, csaddr, (e.mask != 2'b00) ? ea : 32'h0);
                chk({v.name, ".l2addr"}, cl2addr, ea);
                chk({v.name, ".l2wen"}, cwen, e.wen);
                if (e.wen) chk({v.name, ".l2wdata"}, cwdata, e.wdata);
                if (bus_wb[gid]) bus_wb[gid] = 1'b0;
                else             bus_req[gid] = 1'b0;
                got++;
                cmask = 0; cinv = 0; cwen = 0; cwdata = 0; csaddr = 0; cl2addr = 0;
            end
            if (bus_state == SNOOP) begin snoop_done = (sc >= v.sw) ? 2'b11 : 2'b00; sc++; end
            else begin snoop_done = 2'b00; sc = 0; end
            if (l2_ren || l2_wen) begin l2_ready = (lc >= v.lw); lc++; end
            else begin l2_ready = 1'b0; lc = 0; end
        end
        chk({v.name, ".completions"}, got, v.ndone);
        bus_req = 2'b00; bus_wb = 2'b00; snoop_done = 2'b00; l2_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dn;
        nRST = 1'b0;
        bus_req = 0; bus_rx = 0; bus_wb = 0; bus_addr = 0; bus_wdata = 0;
        snoop_done = 0; snoop_hit = 0; snoop_dirty = 0; snoop_data = 0;
        l2_rdata = 0; l2_ready = 0;

        vecs[0] = mk_vec("rd0_miss", 2'b01, 2'b00, 2'b00, 32'h100, 0, 0, 0, 2'b01, 2'b00,
                         0, 0, 32'hDEADBEEF, 0, 0);
        vecs[0].d0 = mk_done(0, 32'hDEADBEEF, 1, 5, 2'b10, 0, 0, 0);
        vecs[1] = mk_vec("rx1_c2c", 2'b10, 2'b10, 2'b00, 0, 32'h200, 0, 0, 2'b01, 2'b01,
                         32'h12345678, 0, 32'hFFFF0000, 0, 0);
        vecs[1].d0 = mk_done(1, 32'h12345678, 1, 5, 2'b01, 1, 1, 32'h12345678);
        vecs[2] = mk_vec("pair_ptr0", 2'b11, 2'b00, 2'b00, 32'h140, 32'h240, 0, 0, 2'b00, 2'b00,
                         0, 0, 32'hA5A50001, 0, 0);
        vecs[2].ndone = 2;
        vecs[2].d0 = mk_done(0, 32'hA5A50001, 1, 5, 2'b10, 0, 0, 0);
        vecs[2].d1 = mk_done(1, 32'hA5A50001, 1, 10, 2'b01, 0, 0, 0);
        vecs[3] = mk_vec("rd0_cleanhit", 2'b01, 2'b00, 2'b00, 32'h180, 0, 0, 0, 2'b10, 2'b00,
                         0, 32'h99999999, 32'h0BADF00D, 0, 0);
        vecs[3].d0 = mk_done(0, 32'h0BADF00D, 0, 5, 2'b10, 0, 0, 0);
        vecs[4] = mk_vec("pair_ptr1", 2'b11, 2'b00, 2'b00, 32'h1C0, 32'h2C0, 0, 0, 2'b00, 2'b00,
                         0, 0, 32'h11112222, 0, 0);
        vecs[4].ndone = 2;
        vecs[4].d0 = mk_done(1, 32'h11112222, 1, 5, 2'b01, 0, 0, 0);
        vecs[4].d1 = mk_done(0, 32'h11112222, 1, 10, 2'b10, 0, 0, 0);
        vecs[5] = mk_vec("wb1_over_rd0", 2'b01, 2'b00, 2'b10, 32'h100, 32'h300, 0, 32'hCAFEF00D,
                         2'b00, 2'b00, 0, 0, 32'h55AA55AA, 0, 0);
        vecs[5].ndone = 2;
        vecs[5].d0 = mk_done(1, 32'h0, 0, 3, 2'b00, 0, 1, 32'hCAFEF00D);
        vecs[5].d1 = mk_done(0, 32'h55AA55AA, 1, 8, 2'b10, 0, 0, 0);
        vecs[6] = mk_vec("cpu0_wb_then_rd", 2'b01, 2'b00, 2'b01, 32'h500, 0, 32'h0F0F0F0F, 0,
                         2'b00, 2'b00, 0, 0, 32'h77778888, 0, 0);
        vecs[6].ndone = 2;
        vecs[6].d0 = mk_done(0, 32'h0, 0, 3, 2'b00, 0, 1, 32'h0F0F0F0F);
        vecs[6].d1 = mk_done(0, 32'h77778888, 1, 8, 2'b10, 0, 0, 0);
        vecs[7] = mk_vec("rx0_miss_wait", 2'b01, 2'b01, 2'b00, 32'h400, 0, 0, 0, 2'b00, 2'b00,
                         0, 0, 32'h13572468, 2, 3);
        vecs[7].d0 = mk_done(0, 32'h13572468, 1, 10, 2'b10, 1, 0, 0);
        vecs[8] = mk_vec("rd1_dirty", 2'b10, 2'b00, 2'b00, 0, 32'h600, 0, 0, 2'b11, 2'b11,
                         32'hABCD0123, 32'hBAD0BAD0, 32'h0, 0, 0);
        vecs[8].d0 = mk_done(1, 32'hABCD0123, 0, 5, 2'b01, 0, 1, 32'hABCD0123);
        vecs[9] = mk_vec("wb_pair_rr", 2'b00, 2'b00, 2'b11, 32'h700, 32'h800, 32'h10101010,
                         32'h20202020, 2'b00, 2'b00, 0, 0, 0, 0, 1);
        vecs[9].ndone = 2;
        vecs[9].d0 = mk_done(0, 32'h0, 0, 4, 2'b00, 0, 1, 32'h10101010);
        vecs[9].d1 = mk_done(1, 32'h0, 0, 8, 2'b00, 0, 1, 32'h20202020);
        vecs[10] = mk_vec("rd1_dropped", 2'b10, 2'b00, 2'b00, 0, 32'hA00, 0, 0, 2'b00, 2'b00,
                          0, 0, 32'h600DCAFE, 0, 0);
        vecs[10].drop = 1'b1;
        vecs[10].d0 = mk_done(1, 32'h600DCAFE, 1, 5, 2'b01, 0, 0, 0);

        repeat (3) @(negedge CLK);
        chk_idle("reset");
        nRST = 1'b1;

        // Reset asserted while a read sits in SNOOP: abort with no completion.
        @(negedge CLK);
        bus_req = 2'b01; bus_rx = 2'b00; bus_addr = {32'h0, 32'h900};
        snoop_done = 2'b00; l2_ready = 1'b0;
        n = 0;
        while (bus_state != SNOOP && n < 10) begin @(negedge CLK); n++; end
        chk("rstsnp.reach", bus_state, SNOOP);
        @(negedge CLK);
        chk("rstsnp.valid", {snoop_valid, snoop_mask}, {1'b1, 2'b10});
        chk("rstsnp.addr", snoop_addr, 32'h900);
        #2 nRST = 1'b0;
        #1 chk_idle("rstsnp");
        bus_req = 2'b00;
        @(negedge CLK);
        nRST = 1'b1;
        dn = 0;
        repeat (8) begin
            @(negedge CLK);
            if (|bus_done) dn++;
        end
        chk("rstsnp.nodone", dn, 0);
        chk("rstsnp.state", bus_state, IDLE);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

`ifdef BUS_SNOOP_TIMEOUT_EN
        @(negedge CLK);
        chk("timeout.clear", timeout_err, 0);
        bus_req = 2'b01; bus_rx = 2'b00; bus_addr = {32'h0, 32'hB00};
        snoop_hit = 2'b00; snoop_dirty = 2'b00; snoop_done = 2'b00;
        l2_ready = 1'b0; l2_rdata = 32'h7E7E7E7E;
        n = 0;
        while (bus_state != SNOOP && n < 10) begin @(negedge CLK); n++; end
        dn = 0;
        while (bus_state == SNOOP && dn < 20) begin dn++; @(negedge CLK); end
        chk("timeout.snoop_cycles", dn, 8);
        chk("timeout.state", bus_state, L2_READ);
        chk("timeout.err", timeout_err, 1);
        l2_ready = 1'b1;
        n = 0;
        while (!bus_done[0] && n < 10) begin @(negedge CLK); n++; end
        chk("timeout.done", bus_done, 2'b01);
        chk("timeout.rdata", bus_rdata, 32'h7E7E7E7E);
        bus_req = 2'b00; l2_ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk("timeout.sticky", timeout_err, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
